// File: rtl/snake_pkg.sv
// Shared direction definitions for the key filter and the game block.
package snake_pkg;

  // Two-bit heading codes; the code value equals the key bit index.
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Bit positions of each push-button inside key_raw.
  localparam int KEY_LEFT  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_RIGHT = 3;

  // Default debounce length: 1 ms at 50 MHz.
  localparam int DEB_CYCLES_DEF = 50000;

  // Left/right and up/down are bitwise complements of each other.
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

  // One-hot key map of a direction code.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/dir_key_filter_if.sv
// Key/direction bundle between the game controller and dir_key_filter.
interface dir_key_filter_if;
  logic [3:0] key_raw;
  logic       move_tick;
  logic [3:0] direction;
  logic [1:0] dir_code;
  logic [1:0] queue_cnt;
  logic       drop_pulse;

  modport master (
    output key_raw, move_tick,
    input  direction, dir_code, queue_cnt, drop_pulse
  );

  modport slave (
    input  key_raw, move_tick,
    output direction, dir_code, queue_cnt, drop_pulse
  );
endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, debounce counter, stable level and
// a single-cycle press strobe on the accepted 0->1 transition.
module key_debounce
  import snake_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic clear_n,
  input  logic key_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             differ;
  logic             done;

  assign differ = sync2_reg ^ stable_reg;
  assign done   = differ && (cnt_reg == CNT_LAST);
  // Strobe in the same cycle the stable level rises, so the filter can act
  // on it at the edge where the level is accepted.
  assign press  = done && !stable_reg;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive disagreeing cycles; flip the level when the run is long enough.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (!differ) begin
      cnt_reg <= '0;
    end else if (done) begin
      cnt_reg    <= '0;
      stable_reg <= ~stable_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/dir_key_filter.sv
// Direction key filter: debounces four buttons, picks one press per cycle,
// rejects presses equal/opposite to the reference heading and queues them.
// Build option DIR_KEY_QUEUE_EN: two-entry queue with drop_pulse on overflow;
// without it a single holding register that newer presses overwrite.
module dir_key_filter
  import snake_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             clear_n,
  dir_key_filter_if.slave bus
);

  logic [3:0] press;
  dir_t       sel;
  logic       sel_valid;
  dir_t       ref_dir;
  logic       push;
  logic       pop;

  dir_t       head_reg, head_next;
  dir_t       last_reg, last_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [3:0] direction_reg;
  dir_t       dir_code_reg;
`ifdef DIR_KEY_QUEUE_EN
  dir_t       tail_reg, tail_next;
  logic       drop_next;
  logic       drop_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_deb (
        .clk    (clk),
        .clear_n(clear_n),
        .key_raw(bus.key_raw[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  // Pick one press per cycle: right > left > up > down.
  always_comb begin
    sel_valid = 1'b1;
    sel       = DIR_RIGHT;
    if (press[KEY_RIGHT])     sel = DIR_RIGHT;
    else if (press[KEY_LEFT]) sel = DIR_LEFT;
    else if (press[KEY_UP])   sel = DIR_UP;
    else if (press[KEY_DOWN]) sel = DIR_DOWN;
    else                      sel_valid = 1'b0;
  end

  // Reference heading is the newest queued entry, else the last consumed one.
`ifdef DIR_KEY_QUEUE_EN
  assign ref_dir = (cnt_reg == 2'd2) ? tail_reg : ((cnt_reg != 2'd0) ? head_reg : last_reg);
`else
  assign ref_dir = (cnt_reg != 2'd0) ? head_reg : last_reg;
`endif

  assign push = sel_valid && (sel != ref_dir) && (sel != dir_opposite(ref_dir));
  assign pop  = bus.move_tick && (cnt_reg != 2'd0);

  // Next queue contents from the pre-cycle state.
  always_comb begin
    head_next = head_reg;
    last_next = last_reg;
    cnt_next  = cnt_reg;
`ifdef DIR_KEY_QUEUE_EN
    tail_next = tail_reg;
    drop_next = 1'b0;
`endif
    if (pop) last_next = head_reg;
`ifdef DIR_KEY_QUEUE_EN
    case ({push, pop})
      2'b11: begin
        // Count unchanged; a full queue shifts up and takes the press at the tail.
        if (cnt_reg == 2'd2) begin
          head_next = tail_reg;
          tail_next = sel;
        end else begin
          head_next = sel;
        end
      end
      2'b10: begin
        case (cnt_reg)
          2'd0: begin
            head_next = sel;
            cnt_next  = 2'd1;
          end
          2'd1: begin
            tail_next = sel;
            cnt_next  = 2'd2;
          end
          default: drop_next = 1'b1;
        endcase
      end
      2'b01: begin
        head_next = tail_reg;
        cnt_next  = cnt_reg - 2'd1;
      end
      default: ;
    endcase
`else
    if (push) begin
      head_next = sel;
      cnt_next  = 2'd1;
    end else if (pop) begin
      cnt_next = 2'd0;
    end
`endif
  end

  // Queue state and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      head_reg      <= DIR_RIGHT;
      last_reg      <= DIR_RIGHT;
      cnt_reg       <= 2'd0;
      direction_reg <= 4'b0000;
      dir_code_reg  <= DIR_RIGHT;
`ifdef DIR_KEY_QUEUE_EN
      tail_reg      <= DIR_RIGHT;
      drop_reg      <= 1'b0;
`endif
    end else begin
      head_reg      <= head_next;
      last_reg      <= last_next;
      cnt_reg       <= cnt_next;
      direction_reg <= (cnt_next != 2'd0) ? dir_onehot(head_next) : 4'b0000;
      dir_code_reg  <= (cnt_next != 2'd0) ? head_next : last_next;
`ifdef DIR_KEY_QUEUE_EN
      tail_reg      <= tail_next;
      drop_reg      <= drop_next;
`endif
    end
  end

  assign bus.direction = direction_reg;
  assign bus.dir_code  = dir_code_reg;
  assign bus.queue_cnt = cnt_reg;
`ifdef DIR_KEY_QUEUE_EN
  assign bus.drop_pulse = drop_reg;
`else
  assign bus.drop_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_dir_key_filter.sv
// Scoreboard bench for dir_key_filter: stimulus queues expected output
// changes (with the cycle they must appear in); a monitor pops and compares
// on every change of the registered outputs.
module tb_dir_key_filter;
  import snake_pkg::*;

  localparam int DEB = 8;

  logic clk = 1'b0;
  logic clear_n = 1'b1;
  always #5 clk = ~clk;

  dir_key_filter_if bus ();

  dir_key_filter #(
    .DEB_CYCLES(DEB),
    .CNT_W     (4)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] dir;
    logic [1:0] code;
    logic [1:0] cnt;
    logic       drop;
    int         at;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output change must match the oldest expectation.
  initial begin
    logic [8:0] obs;
    logic [8:0] prev_obs;
    exp_t       e;
    prev_obs = '0;
    forever begin
      @(negedge clk);
      obs = {bus.direction, bus.dir_code, bus.queue_cnt, bus.drop_pulse};
      if (mon_en && obs !== prev_obs) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got dir=%b code=%b cnt=%0d drop=%b at cycle %0d, required no change",
                   obs[8:5], obs[4:3], obs[2:1], obs[0], cyc);
        end else begin
          e = sb.pop_front();
          if (obs !== {e.dir, e.code, e.cnt, e.drop} || cyc != e.at) begin
            errors++;
            $display("FAIL %s: got dir=%b code=%b cnt=%0d drop=%b at cycle %0d, required dir=%b code=%b cnt=%0d drop=%b at cycle %0d",
                     e.name, obs[8:5], obs[4:3], obs[2:1], obs[0], cyc,
                     e.dir, e.code, e.cnt, e.drop, e.at);
          end else begin
            $display("ok   %s: dir=%b code=%b cnt=%0d drop=%b at cycle %0d",
                     e.name, obs[8:5], obs[4:3], obs[2:1], obs[0], cyc);
          end
        end
      end
      prev_obs = obs;
    end
  end

  task automatic expect_at(input logic [3:0] d, input logic [1:0] c, input logic [1:0] n,
                           input logic dp, input int at, input string nm);
    exp_t e;
    e.dir = d; e.code = c; e.cnt = n; e.drop = dp; e.at = at; e.name = nm;
    sb.push_back(e);
    last_exp = e;
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold keys long enough to be accepted, optionally ticking in the accept cycle.
  task automatic press(input logic [3:0] keys, input bit tick);
    bus.key_raw = keys;
    if (tick) begin
      step(DEB + 1);
      bus.move_tick = 1'b1;
      step(1);
      bus.move_tick = 1'b0;
      step(3);
    end else begin
      step(DEB + 5);
    end
    bus.key_raw = 4'b0000;
    step(DEB + 5);
  endtask

  task automatic pulse_move();
    bus.move_tick = 1'b1;
    step(1);
    bus.move_tick = 1'b0;
    step(2);
  endtask

  // Reset asserted mid-cycle, released just after a rising edge.
  task automatic do_reset();
    #2 clear_n = 1'b0;
    step(2);
    clear_n = 1'b1;
  endtask

  // Outputs must sit at the last expected value with nothing outstanding.
  task automatic idle_check(input string nm);
    logic [8:0] obs;
    obs = {bus.direction, bus.dir_code, bus.queue_cnt, bus.drop_pulse};
    checks++;
    if (sb.size() != 0 || obs !== {last_exp.dir, last_exp.code, last_exp.cnt, last_exp.drop}) begin
      errors++;
      $display("FAIL %s: got dir=%b code=%b cnt=%0d drop=%b pending=%0d, required dir=%b code=%b cnt=%0d drop=%b pending=0",
               nm, obs[8:5], obs[4:3], obs[2:1], obs[0], sb.size(),
               last_exp.dir, last_exp.code, last_exp.cnt, last_exp.drop);
    end else begin
      $display("ok   %s: dir=%b code=%b cnt=%0d drop=%b", nm, obs[8:5], obs[4:3], obs[2:1], obs[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_raw   = 4'b0000;
    bus.move_tick = 1'b0;
    #2 clear_n = 1'b0;
    #20;
    last_exp.dir = 4'b0000; last_exp.code = 2'b11; last_exp.cnt = 2'd0; last_exp.drop = 1'b0;
    last_exp.at = 0; last_exp.name = "reset";
    idle_check("reset_values");
    mon_en = 1'b1;
    @(posedge clk);
    #1 clear_n = 1'b1;
    step(2);

    // Short glitches never reach the debounce length.
    bus.key_raw[1] = 1'b1; step(3);
    bus.key_raw[1] = 1'b0; step(1);
    bus.key_raw[1] = 1'b1; step(1);
    bus.key_raw[1] = 1'b0; step(DEB + 5);
    idle_check("glitch_no_press");

    expect_at(4'b0010, 2'b01, 2'd1, 1'b0, cyc + DEB + 2, "press_up");
    press(4'b0010, 1'b0);
    expect_at(4'b0000, 2'b01, 2'd0, 1'b0, cyc + 1, "pop_up");
    pulse_move();
    expect_at(4'b0001, 2'b00, 2'd1, 1'b0, cyc + DEB + 2, "push_with_tick_on_empty");
    press(4'b0001, 1'b1);
    expect_at(4'b0000, 2'b00, 2'd0, 1'b0, cyc + 1, "pop_left");
    pulse_move();

    expect_at(4'b0000, 2'b11, 2'd0, 1'b0, cyc, "reset_idle");
    do_reset();
    press(4'b0001, 1'b0);
    idle_check("left_opposite_start");
    press(4'b1000, 1'b0);
    idle_check("right_equal_ref");

    expect_at(4'b0010, 2'b01, 2'd1, 1'b0, cyc + DEB + 2, "press_up2");
    press(4'b0010, 1'b0);
`ifdef DIR_KEY_QUEUE_EN
    expect_at(4'b0010, 2'b01, 2'd2, 1'b0, cyc + DEB + 2, "queue_left");
    press(4'b0001, 1'b0);
    expect_at(4'b0010, 2'b01, 2'd2, 1'b1, cyc + DEB + 2, "drop_down");
    expect_at(4'b0010, 2'b01, 2'd2, 1'b0, cyc + DEB + 3, "drop_end");
    press(4'b0100, 1'b0);
    idle_check("full_holds_up_left");
    expect_at(4'b0001, 2'b00, 2'd2, 1'b0, cyc + DEB + 2, "full_push_pop");
    press(4'b0100, 1'b1);
`else
    expect_at(4'b0001, 2'b00, 2'd1, 1'b0, cyc + DEB + 2, "overwrite_left");
    press(4'b0001, 1'b0);
    expect_at(4'b0100, 2'b10, 2'd1, 1'b0, cyc + DEB + 2, "overwrite_down");
    press(4'b0100, 1'b0);
    press(4'b0010, 1'b0);
    idle_check("up_opposite_down");
    expect_at(4'b1000, 2'b11, 2'd1, 1'b0, cyc + DEB + 2, "push_pop_right");
    press(4'b1000, 1'b1);
`endif

    // Reset with a full/occupied queue and a key mid-debounce; key stays held.
    bus.key_raw = 4'b0010;
    step(4);
    expect_at(4'b0000, 2'b11, 2'd0, 1'b0, cyc, "reset_mid");
    do_reset();
    expect_at(4'b0010, 2'b01, 2'd1, 1'b0, cyc + DEB + 2, "held_through_reset");
    step(DEB + 5);
    bus.key_raw = 4'b0000;
    step(DEB + 5);

    // Right, left and down together: right wins.
`ifdef DIR_KEY_QUEUE_EN
    expect_at(4'b0010, 2'b01, 2'd2, 1'b0, cyc + DEB + 2, "priority_right");
    press(4'b1101, 1'b0);
    expect_at(4'b1000, 2'b11, 2'd1, 1'b0, cyc + 1, "pop_head");
    pulse_move();
    expect_at(4'b0000, 2'b11, 2'd0, 1'b0, cyc + 1, "pop_last");
    pulse_move();
`else
    expect_at(4'b1000, 2'b11, 2'd1, 1'b0, cyc + DEB + 2, "priority_right");
    press(4'b1101, 1'b0);
    expect_at(4'b0000, 2'b11, 2'd0, 1'b0, cyc + 1, "pop_last");
    pulse_move();
`endif
    pulse_move();
    idle_check("tick_on_empty");

    for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
    idle_check("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
